// File: rtl/alu_pkg.sv
// Shared types and defaults for the sequential multiplier slice.
package alu_pkg;
   localparam int OP_W_DEF = 8;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/booth_mul_step.sv
// One radix-2 Booth iteration: add/sub selected by {q[0],q_1}, then arithmetic
// right shift of the combined {acc,q,q_1} register.
module booth_step
   import alu_pkg::*;
#(
   parameter int OP_W = OP_W_DEF
) (
   input  logic signed [OP_W:0]   acc,
   input  logic signed [OP_W-1:0] m,
   input  logic        [OP_W-1:0] q,
   input  logic                   q_1,
   output logic signed [OP_W:0]   acc_n,
   output logic        [OP_W-1:0] q_n,
   output logic                   q_1_n
);
   logic signed [OP_W:0] m_x;
   logic signed [OP_W:0] sum;

   assign m_x = {m[OP_W-1], m};

   always_comb begin
      sum = acc;
      case ({q[0], q_1})
         2'b10:   sum = acc - m_x;
         2'b01:   sum = acc + m_x;
         default: sum = acc;
      endcase
   end

   assign acc_n = {sum[OP_W], sum[OP_W:1]};
   assign q_n   = {sum[0], q[OP_W-1:1]};
   assign q_1_n = q[0];
endmodule

// File: rtl/booth_mul.sv
// Radix-2 Booth sequential signed multiplier, OP_W steps per operation.
// BOOTH_MUL_EARLY_ZERO_EN: zero operands bypass CALC and finish one cycle after accept.
module booth_mul
   import alu_pkg::*;
#(
   parameter int OP_W = OP_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic signed [OP_W-1:0]   a,
   input  logic signed [OP_W-1:0]   b,
   output logic signed [2*OP_W-1:0] product,
   output logic                     done
);
   localparam int CW = $clog2(OP_W + 1);

   state_t               state, state_n;
   logic signed [OP_W:0] acc, acc_n;
   logic signed [OP_W-1:0] m;
   logic [OP_W-1:0]      q, q_n;
   logic                 q_1, q_1_n;
   logic [CW-1:0]        count;
   logic                 zero_op;
   logic                 load, step_en, finish;

`ifdef BOOTH_MUL_EARLY_ZERO_EN
   assign zero_op = (a == '0) || (b == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = zero_op ? DONE : CALC;
         CALC:    if (count == CW'(1)) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      load    = (state == IDLE) && start;
      step_en = (state == CALC);
      finish  = (state == DONE);
   end

   booth_step #(.OP_W(OP_W)) u_step (
      .acc   (acc),
      .m     (m),
      .q     (q),
      .q_1   (q_1),
      .acc_n (acc_n),
      .q_n   (q_n),
      .q_1_n (q_1_n)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         m       <= '0;
         q       <= '0;
         q_1     <= 1'b0;
         acc     <= '0;
         count   <= '0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            m     <= a;
            // Zeroing q makes the bypassed result come out as 0 from the DONE path
            q     <= zero_op ? '0 : b;
            q_1   <= 1'b0;
            acc   <= '0;
            count <= CW'(OP_W);
         end else if (step_en) begin
            acc   <= acc_n;
            q     <= q_n;
            q_1   <= q_1_n;
            count <= count - CW'(1);
         end
         if (finish) product <= {acc[OP_W-1:0], q};
      end
   end
endmodule

// File: tb/tb_booth_mul.sv
// Randomized and directed checks of booth_mul against plain signed multiplication.
module tb_booth_mul;
   import alu_pkg::*;
   localparam int W = 8;

   logic                    clk = 1'b0;
   logic                    reset, start;
   logic signed [W-1:0]     a, b;
   logic signed [2*W-1:0]   product;
   logic                    done;
   int                      n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   booth_mul #(.OP_W(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .product (product),
      .done    (done)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input int x, input int y);
`ifdef BOOTH_MUL_EARLY_ZERO_EN
      return (x == 0 || y == 0) ? 1 : W + 1;
`else
      return W + 1;
`endif
   endfunction

   task automatic run_op(input int x, input int y, input string tag);
      int lat;
      bit held;
      logic signed [2*W-1:0] prev;
      @(negedge clk);
      a = W'(x); b = W'(y); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      prev = product; lat = -1; held = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done) begin lat = n; break; end
         if (product !== prev) held = 1'b0;
      end
      chk({tag, "_hold"}, held, 1);
      chk({tag, "_lat"}, lat, exp_lat(x, y));
      chk({tag, "_prod"}, product, x * y);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, done, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, ndone, x, y;
      reset = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_prod", product, 0);
      chk("rst_done", done, 0);
      chk("rst_state", int'(dut.state), int'(IDLE));
      @(negedge clk) reset = 1'b0;

      run_op(25, 5, "basic");
      run_op(-25, 5, "neg_a");
      run_op(25, -5, "neg_b");
      run_op(-25, -5, "neg_ab");
      run_op(-128, -128, "min_min");
      run_op(-128, 127, "min_max");
      run_op(127, 127, "max_max");
      run_op(0, 5, "zero_a");
      run_op(5, 0, "zero_b");

      // second start during CALC must be ignored
      @(negedge clk); a = 54; b = 7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      ndone = 0; lat = -1;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (n == 3) begin a = 99; start = 1'b1; end
         if (n == 4) start = 1'b0;
         if (done) begin ndone++; if (lat < 0) lat = n; end
      end
      chk("ign_lat", lat, W + 1);
      chk("ign_ndone", ndone, 1);
      chk("ign_prod", product, 378);

      // reset at CALC step 4 aborts silently
      @(negedge clk); a = 54; b = 7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      chk("abort_prod", product, 0);
      chk("abort_state", int'(dut.state), int'(IDLE));
      ndone = 0;
      for (int n = 0; n < 15; n++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("abort_ndone", ndone, 0);
      chk("abort_prod2", product, 0);
      run_op(54, -7, "after_abort");

      // reset and start together stay idle
      @(negedge clk); reset = 1'b1; start = 1'b1; a = 3; b = 3;
      @(posedge clk); #1; reset = 1'b0; start = 1'b0;
      chk("rst_start_state", int'(dut.state), int'(IDLE));
      ndone = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("rst_start_ndone", ndone, 0);

      // start held high: back-to-back with one idle cycle
      @(negedge clk); a = 3; b = -7; start = 1'b1;
      @(posedge clk); #1;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done) begin lat = n; break; end
      end
      chk("b2b_lat1", lat, W + 1);
      chk("b2b_prod1", product, -21);
      a = -9; b = 11;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done) begin lat = n; break; end
      end
      start = 1'b0;
      chk("b2b_lat2", lat, W + 2);
      chk("b2b_prod2", product, -99);

      for (int i = 0; i < 40; i++) begin
         x = int'($urandom_range(0, 255)) - 128;
         y = int'($urandom_range(0, 255)) - 128;
         if (i % 10 == 3) x = -128;
         if (i % 10 == 7) y = 0;
         run_op(x, y, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/booth_mul.md
BOOTH_MUL -- requirements
Module: booth_mul

Interface
REQ-001 The module SHALL have a parameter OP_W, default 8, giving the signed operand width; the product width is 2*OP_W.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-005 The module SHALL have port a, input, OP_W bits signed: the multiplicand, captured when start is accepted.
REQ-006 The module SHALL have port b, input, OP_W bits signed: the multiplier, captured when start is accepted.
REQ-007 The module SHALL have port product, output, 2*OP_W bits signed, registered: the result of the last completed operation.
REQ-008 The module SHALL have port done, output, 1 bit, registered: a one-cycle completion pulse.

Function
REQ-009 The module SHALL implement a radix-2 Booth sequential multiplier with three states: IDLE, CALC and DONE.
REQ-010 IDLE SHALL accept the operation when start=1 at a rising edge: load M=a, Q=b, Q_1=0, acc=0, count=OP_W, and go to CALC.
REQ-011 Each CALC cycle SHALL perform one Booth step on {Q[0],Q_1}:
- 10: acc = acc - M
- 01: acc = acc + M
- 00 or 11: no add
- then an arithmetic right shift of {acc,Q,Q_1} and a decrement of count.
REQ-012 acc SHALL be OP_W+1 bits wide so that subtracting M = -2^(OP_W-1) does not overflow.
REQ-013 When count reaches 0, the FSM SHALL go to DONE. DONE SHALL register product = {acc[OP_W-1:0], Q}, set done=1 for exactly one cycle, and then return to IDLE.
REQ-014 Latency: if start is accepted at edge k, then product and done SHALL be valid in the cycle after edge k+OP_W+1 (edge k+9 for OP_W=8).
REQ-015 start asserted in CALC or DONE SHALL be ignored; changes to a and b after acceptance SHALL NOT affect the result.
REQ-016 start held high continuously SHALL begin a new operation on the first IDLE edge after DONE, with one idle cycle between operations.
REQ-017 product SHALL hold its value until the next DONE and SHALL NOT change during CALC.
REQ-018 The result SHALL equal the exact signed product for every operand pair, including -128*-128 = 16384 and -128*127 = -16256.

Reset
REQ-019 When reset=1 at a rising edge, the module SHALL set state to IDLE, product to 0, done to 0, and acc, Q, Q_1 and count to 0.
REQ-020 reset SHALL take priority over start and over any in-progress operation. An operation aborted by reset SHALL produce no done pulse and SHALL leave product at 0.
REQ-021 With reset and start both high on the same edge, the module SHALL stay in IDLE.

Configuration
REQ-022 With macro BOOTH_MUL_EARLY_ZERO_EN defined, an operation accepted with a==0 or b==0 SHALL skip CALC and go directly to DONE, giving product=0 and done in the cycle after edge k+1.
REQ-023 Without BOOTH_MUL_EARLY_ZERO_EN, every operation SHALL take the full OP_W+1 cycle latency, and zero operands SHALL give product=0 through the normal path.

Structure
REQ-024 The shared package alu_pkg SHALL hold the FSM state typedef (IDLE, CALC, DONE) and the default width constant OP_W_DEF=8.
REQ-025 The combinational step (add/sub selection plus arithmetic shift) SHALL be a sub-module named booth_step. The FSM, counter and output registers SHALL stay in booth_mul.

Verification
REQ-026 a=25, b=5, start pulsed for one cycle -> product=125, done high for exactly one cycle, 9 edges after acceptance.
REQ-027 The sign cases SHALL be covered:
- (-25,5) -> -125
- (25,-5) -> -125
- (-25,-5) -> 125
REQ-028 The boundary cases SHALL be covered:
- (-128,-128) -> 16384
- (-128,127) -> -16256
- (127,127) -> 16129
REQ-029 a=0, b=5 -> product=0. With BOOTH_MUL_EARLY_ZERO_EN, done follows 1 edge after acceptance; without it, done follows 9 edges after acceptance.
REQ-030 Start (54,7), change a to 99 and pulse start again during CALC -> product=378, exactly one done pulse, and the second start is ignored.
REQ-031 Start (54,7), then assert reset for one cycle at CALC step 4 -> product=0, no done pulse, FSM in IDLE. A following (54,-7) -> -378.
